// File: rtl/div5_monitor.sv
// Divided-clock monitor: samples t_in on clk, measures period and high time,
// declares lock after consecutive in-spec periods and flags faults.
module div5_monitor #(
  parameter int EXP_PERIOD = 5,
  parameter int EXP_HIGH   = 3,
  parameter int HIGH_TOL   = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 32,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          t_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_cnt,
  output logic          meas_valid,
  output logic          lock,
  output logic          err,
  output logic [7:0]    err_cnt
);
  localparam int MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, SEEK, MEASURE, LOCKED} state_t;

  state_t          state, state_d;
  logic            s1, s2, prev, rise;
  logic [CW-1:0]   pcnt, pcnt_d, hcnt, hcnt_d, hdiff;
  logic [CW-1:0]   period_d, high_d;
  logic [MW-1:0]   mcnt, mcnt_d;
  logic            mv_d, match, timeout, fault;
  logic [7:0]      err_cnt_d;

  assign rise    = s2 & ~prev;
  assign hdiff   = (hcnt >= CW'(EXP_HIGH)) ? hcnt - CW'(EXP_HIGH) : CW'(EXP_HIGH) - hcnt;
  assign match   = (pcnt == CW'(EXP_PERIOD)) && (hdiff <= CW'(HIGH_TOL));
  assign timeout = (pcnt == CW'(TIMEOUT)) && !rise;
  assign lock    = (state == LOCKED);

  always_comb begin
    state_d  = state;
    pcnt_d   = pcnt;
    hcnt_d   = hcnt;
    mcnt_d   = mcnt;
    period_d = period;
    high_d   = high_cnt;
    mv_d     = 1'b0;
    fault    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      pcnt_d  = '0;
      hcnt_d  = '0;
      mcnt_d  = '0;
    end else if (state == IDLE) begin
      state_d = SEEK;
    end else begin
      if (rise) begin
        pcnt_d = CW'(1);
        hcnt_d = CW'(1);
      end else begin
        if (pcnt != '1) pcnt_d = pcnt + 1'b1;
        if (s2 && (hcnt != '1)) hcnt_d = hcnt + 1'b1;
      end
      // timeout restarts the period count at 1 so repeats land every TIMEOUT cycles
      if (timeout) begin
        fault   = 1'b1;
        state_d = SEEK;
        pcnt_d  = CW'(1);
        hcnt_d  = '0;
      end else if (rise) begin
        case (state)
          SEEK: begin
            state_d = MEASURE;
            mcnt_d  = '0;
          end
          MEASURE: begin
            period_d = pcnt;
            high_d   = hcnt;
            mv_d     = 1'b1;
            if (match) begin
              mcnt_d = mcnt + 1'b1;
              if (mcnt == MW'(LOCK_CNT - 1)) state_d = LOCKED;
            end else begin
              mcnt_d = '0;
              fault  = 1'b1;
            end
          end
          LOCKED: begin
            period_d = pcnt;
            high_d   = hcnt;
            mv_d     = 1'b1;
            if (!match) begin
              mcnt_d  = '0;
              fault   = 1'b1;
              state_d = MEASURE;
            end
          end
          default: ;
        endcase
      end
    end
    err_cnt_d = (fault && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      prev       <= 1'b0;
      state      <= IDLE;
      pcnt       <= '0;
      hcnt       <= '0;
      mcnt       <= '0;
      period     <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      s1         <= t_in;
      s2         <= s1;
      prev       <= s2;
      state      <= state_d;
      pcnt       <= pcnt_d;
      hcnt       <= hcnt_d;
      mcnt       <= mcnt_d;
      period     <= period_d;
      high_cnt   <= high_d;
      meas_valid <= mv_d;
      err        <= fault;
      err_cnt    <= err_cnt_d;
    end
  end

endmodule
